// File: rtl/sd_clk_switch_ctrl.sv
// SD clock source controller: power-up slow-clock interval, then glitch-safe slow/fast switching gated on bus idle.
// Latency: every output is a register; a granted switch holds oclk_en low for SETTLE_CYCLES and then pulses oack.
// Backpressure: a pending switch waits in WAIT_IDLE, indefinitely, until ibus_idle is high; a withdrawn request cancels it.
module sd_clk_switch_ctrl #(
    parameter int INIT_CYCLES   = 2000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic iclk,
    input  logic irst,
    input  logic ireq_fast,
    input  logic ibus_idle,
    output logic osel_clk,
    output logic oclk_en,
    output logic oack,
    output logic oinit_done,
    output logic obusy
);

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_IDLE      = 2'd1,
        ST_WAIT_IDLE = 2'd2,
        ST_SETTLE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sel_nxt;
    logic             en_nxt;
    logic             ack_nxt;
    logic             done_nxt;
    logic             busy_nxt;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state      <= ST_INIT;
            cnt        <= '0;
            osel_clk   <= 1'b0;
            oclk_en    <= 1'b0;
            oack       <= 1'b0;
            oinit_done <= 1'b0;
            obusy      <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            osel_clk   <= sel_nxt;
            oclk_en    <= en_nxt;
            oack       <= ack_nxt;
            oinit_done <= done_nxt;
            obusy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = osel_clk;
        en_nxt    = oclk_en;
        ack_nxt   = 1'b0;
        done_nxt  = oinit_done;

        unique case (state)
            ST_INIT: begin
                sel_nxt = 1'b0;
                en_nxt  = 1'b1;
                // The first edge out of reset only enables the slow clock; counting starts once it runs.
                if (oclk_en) begin
                    if (cnt == INIT_LAST) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            ST_IDLE: begin
                if (ireq_fast != osel_clk) begin
                    state_nxt = ST_WAIT_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                if (ireq_fast == osel_clk) begin
                    state_nxt = ST_IDLE;
                end else if (ibus_idle) begin
                    sel_nxt   = ~osel_clk;
                    en_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    en_nxt    = 1'b1;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
                sel_nxt   = 1'b0;
                en_nxt    = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule
